// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage core:
// occupancy encoding, bubble payload and the per-boundary payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // An all-zero payload is a bubble; replicate this bit to any payload width.
  localparam logic BUBBLE_BIT = 1'b0;

  localparam int FD_PAYLOAD_W = 64;
  localparam int DX_PAYLOAD_W = 128;
  localparam int XM_PAYLOAD_W = 96;
  localparam int MW_PAYLOAD_W = 72;

  function automatic logic occ_has_room(occ_e occ);
    return occ != OCC_FULL;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with optional skid entry, flush and a
// stall-cycle counter. Payload is opaque; parents concatenate stage fields.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit SKID_EN    = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_count,
  input  logic                  stall_count_clr
);

  localparam logic [DATA_WIDTH-1:0] BUBBLE = {DATA_WIDTH{BUBBLE_BIT}};

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  valid_q;
  logic                  accept;
  logic                  emit;

  assign accept = in_valid & in_ready;
  assign emit   = valid_q & out_ready;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d  = OCC_EMPTY;
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d = in_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept && SKID_EN) begin
            skid_d = in_data;
            occ_d  = OCC_FULL;
          end else if (emit) begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (emit) begin
            main_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: payload registers are reset too, so out_data reads as a bubble after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q   <= OCC_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (occ_d != OCC_EMPTY);
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic ready_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= occ_has_room(occ_d);
        end
      end
      assign in_ready = ready_q;
    end else begin : g_single
      assign in_ready = !valid_q | out_ready;
    end
  endgenerate

  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (valid_q & ~out_ready),
    .clr   (stall_count_clr),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: skid (A), 2-bit counter skid (C, shares A's inputs) and
// single-entry (B) instances checked against queue-based reference models.
module tb_pipe_stage_reg;

  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          a_flush, a_valid, a_oready, a_clr;
  logic [DW-1:0] a_data;
  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall;

  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [1:0]    c_occ;
  logic [1:0]    c_stall;

  logic          b_flush, b_valid, b_oready, b_clr;
  logic [DW-1:0] b_data;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_stall;

  pipe_stage_reg #(.DATA_WIDTH(DW), .SKID_EN(1'b1), .CNT_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .flush(a_flush),
    .in_valid(a_valid), .in_ready(a_in_ready), .in_data(a_data),
    .out_valid(a_out_valid), .out_ready(a_oready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_count(a_stall), .stall_count_clr(a_clr)
  );

  pipe_stage_reg #(.DATA_WIDTH(DW), .SKID_EN(1'b1), .CNT_WIDTH(2)) dut_c (
    .clock(clock), .reset(reset), .flush(a_flush),
    .in_valid(a_valid), .in_ready(c_in_ready), .in_data(a_data),
    .out_valid(c_out_valid), .out_ready(a_oready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_count(c_stall), .stall_count_clr(a_clr)
  );

  pipe_stage_reg #(.DATA_WIDTH(DW), .SKID_EN(1'b0), .CNT_WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .flush(b_flush),
    .in_valid(b_valid), .in_ready(b_in_ready), .in_data(b_data),
    .out_valid(b_out_valid), .out_ready(b_oready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_count(b_stall), .stall_count_clr(b_clr)
  );

  // Reference model: FIFO contents, "out_data is a bubble" flags, stall counts.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit            za, zb;
  int            sa, sb, sc;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    za = 1'b1;
    zb = 1'b1;
    sa = 0;
    sb = 0;
    sc = 0;
  endtask

  task automatic check_outputs();
    check("a_occupancy", 32'(a_occ), 32'(qa.size()));
    check("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
    check("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 2));
    if (qa.size() != 0) check("a_out_data", 32'(a_out_data), 32'(qa[0]));
    else if (za) check("a_out_data_bubble", 32'(a_out_data), 32'h0);
    check("a_stall_count", 32'(a_stall), 32'(sa));
    check("c_occupancy", 32'(c_occ), 32'(qa.size()));
    check("c_out_valid", 32'(c_out_valid), 32'(qa.size() != 0));
    check("c_in_ready", 32'(c_in_ready), 32'(qa.size() < 2));
    if (qa.size() != 0) check("c_out_data", 32'(c_out_data), 32'(qa[0]));
    check("c_stall_count", 32'(c_stall), 32'(sc));
    check("b_occupancy", 32'(b_occ), 32'(qb.size()));
    check("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
    check("b_in_ready", 32'(b_in_ready), 32'(qb.size() == 0 || b_oready));
    if (qb.size() != 0) check("b_out_data", 32'(b_out_data), 32'(qb[0]));
    else if (zb) check("b_out_data_bubble", 32'(b_out_data), 32'h0);
    check("b_stall_count", 32'(b_stall), 32'(sb));
  endtask

  task automatic model_step();
    bit acc_a, acc_b;
    acc_a = a_valid && (qa.size() < 2);
    acc_b = b_valid && (qb.size() == 0 || b_oready);
    if (a_clr) begin
      sa = 0;
      sc = 0;
    end else if (qa.size() != 0 && !a_oready) begin
      if (sa < 65535) sa++;
      if (sc < 3) sc++;
    end
    if (b_clr) sb = 0;
    else if (qb.size() != 0 && !b_oready && sb < 65535) sb++;
    if (a_flush) begin
      qa.delete();
      za = 1'b1;
    end else begin
      if (qa.size() != 0 && a_oready) begin
        void'(qa.pop_front());
        za = 1'b0;
      end
      if (acc_a) begin
        qa.push_back(a_data);
        za = 1'b0;
      end
    end
    if (b_flush) begin
      qb.delete();
      zb = 1'b1;
    end else begin
      if (qb.size() != 0 && b_oready) begin
        void'(qb.pop_front());
        zb = 1'b0;
      end
      if (acc_b) begin
        qb.push_back(b_data);
        zb = 1'b0;
      end
    end
  endtask

  // Called at a falling edge after inputs are set; leaves us at the next falling edge.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    {a_flush, a_valid, a_oready, a_clr, a_data} = '0;
    {b_flush, b_valid, b_oready, b_clr, b_data} = '0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_outputs();
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Streaming at full throughput.
    a_valid = 1'b1;
    a_oready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_data = DW'(i);
      tick();
    end
    a_valid = 1'b0;
    repeat (2) tick();

    // Back-pressure fills the skid entry, then drains in order.
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    a_oready = 1'b0;
    a_valid = 1'b1;
    a_data = 8'h0A;
    tick();
    a_data = 8'h0B;
    tick();
    a_valid = 1'b0;
    a_data = 8'h00;
    repeat (4) tick();
    #1;
    check("bp_stall_count", 32'(a_stall), 32'd5);
    check("bp_occupancy_full", 32'(a_occ), 32'd2);
    a_oready = 1'b1;
    repeat (3) tick();

    // Flush while FULL with a simultaneous offered payload.
    a_oready = 1'b0;
    a_valid = 1'b1;
    a_data = 8'h0A;
    tick();
    a_data = 8'h0B;
    tick();
    a_data = 8'h0C;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_valid = 1'b0;
    a_oready = 1'b1;
    repeat (3) tick();

    // Single-entry variant: combinational in_ready under back-pressure.
    b_valid = 1'b1;
    b_data = 8'h05;
    b_oready = 1'b0;
    tick();
    b_data = 8'h06;
    tick();
    b_oready = 1'b1;
    tick();
    b_valid = 1'b0;
    repeat (2) tick();

    // Narrow counter saturates; clear beats a concurrent stall.
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    a_valid = 1'b1;
    a_data = 8'h11;
    a_oready = 1'b0;
    tick();
    a_valid = 1'b0;
    repeat (6) tick();
    #1;
    check("c_stall_saturated", 32'(c_stall), 32'd3);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    tick();
    a_oready = 1'b1;
    repeat (2) tick();

    // Asynchronous reset between clock edges while holding data.
    a_oready = 1'b0;
    a_valid = 1'b1;
    b_oready = 1'b0;
    b_valid = 1'b1;
    a_data = 8'h21;
    b_data = 8'h33;
    tick();
    a_data = 8'h22;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_occupancy", 32'(a_occ), 32'd0);
    check("rst_a_out_data", 32'(a_out_data), 32'd0);
    check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_a_stall", 32'(a_stall), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_out_data", 32'(b_out_data), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    a_valid = 1'b1;
    a_data = 8'h44;
    a_oready = 1'b1;
    tick();
    a_valid = 1'b0;
    repeat (2) tick();

    // Randomized traffic on both variants.
    for (int n = 0; n < 600; n++) begin
      a_valid  = ($urandom_range(0, 3) != 0);
      a_data   = DW'($urandom);
      a_oready = ($urandom_range(0, 2) != 0);
      a_flush  = ($urandom_range(0, 24) == 0);
      a_clr    = ($urandom_range(0, 39) == 0);
      b_valid  = ($urandom_range(0, 3) != 0);
      b_data   = DW'($urandom);
      b_oready = ($urandom_range(0, 2) != 0);
      b_flush  = ($urandom_range(0, 24) == 0);
      b_clr    = ($urandom_range(0, 39) == 0);
      tick();
    end
    {a_flush, a_valid, a_clr, b_flush, b_valid, b_clr} = '0;
    a_oready = 1'b1;
    b_oready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
